// File: rtl/smpc_pkg.sv
// Shared types and constants for the SMPC INTBACK peripheral sequencer.
// Status and pad ID values follow the SMPC peripheral report framing.
package smpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_WAIT_CONT,
        ST_REARM,
        ST_SKIP
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_STATUS,
        PH_ID,
        PH_DATA
    } parse_phase_e;

    localparam logic [7:0] PERIPH_UNCONNECTED = 8'hF0;
    localparam logic [7:0] PERIPH_DIRECT      = 8'hF1;

    localparam logic [7:0] PAD_ID_DIGITAL      = 8'h02;
    localparam logic [7:0] PAD_ID_WHEEL        = 8'h13;
    localparam logic [7:0] PAD_ID_MISSION      = 8'h15;
    localparam logic [7:0] PAD_ID_3D           = 8'h16;
    localparam logic [7:0] PAD_ID_DUAL_MISSION = 8'h19;

    // A status byte whose low nibble is zero reports an empty port.
    function automatic logic isUnconnected(input logic [7:0] status);
        return status[3:0] == PERIPH_UNCONNECTED[3:0];
    endfunction

endpackage

// File: rtl/periph_stream_parser.sv
// Walks the per-port STATUS/ID/DATA framing and flags when every port record has been seen.
// complete_o already reflects the byte being accepted this cycle.
module periph_stream_parser
    import smpc_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    output logic       complete_o
);

    localparam int             CW         = $clog2(NUM_PORTS + 1);
    localparam logic [CW-1:0]  PORTS_DONE = CW'(NUM_PORTS);

    logic [CW-1:0] portCnt_q, portCnt_d;
    parse_phase_e  phase_q, phase_d;
    logic [3:0]    dataLeft_q, dataLeft_d;

    always_comb begin
        portCnt_d  = portCnt_q;
        phase_d    = phase_q;
        dataLeft_d = dataLeft_q;
        if (load_i) begin
            portCnt_d  = '0;
            phase_d    = PH_STATUS;
            dataLeft_d = 4'd0;
        end else if (valid_i && portCnt_q != PORTS_DONE) begin
            case (phase_q)
                PH_STATUS: begin
                    if (isUnconnected(byte_i)) portCnt_d = portCnt_q + CW'(1);
                    else                       phase_d   = PH_ID;
                end
                PH_ID: begin
                    dataLeft_d = byte_i[3:0];
                    if (byte_i[3:0] == 4'd0) begin
                        portCnt_d = portCnt_q + CW'(1);
                        phase_d   = PH_STATUS;
                    end else begin
                        phase_d   = PH_DATA;
                    end
                end
                PH_DATA: begin
                    dataLeft_d = dataLeft_q - 4'd1;
                    if (dataLeft_q == 4'd1) begin
                        portCnt_d = portCnt_q + CW'(1);
                        phase_d   = PH_STATUS;
                    end
                end
                default: phase_d = PH_STATUS;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            portCnt_q  <= '0;
            phase_q    <= PH_STATUS;
            dataLeft_q <= 4'd0;
        end else begin
            portCnt_q  <= portCnt_d;
            phase_q    <= phase_d;
            dataLeft_q <= dataLeft_d;
        end
    end

    assign complete_o = (portCnt_d == PORTS_DONE);

endmodule

// File: rtl/smpc_periph_seq.sv
// INTBACK peripheral-data sequencer: captures the pad serializer stream into the OREG
// window, one chunk at a time, replaying and skipping already-delivered bytes on CONT.
module smpc_periph_seq
    import smpc_pkg::*;
#(
    parameter int OREG_SIZE = 32,
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SMPC_CE,
    input  logic       START,
    input  logic       CONT,
    input  logic       BREAK,
    output logic       INPUT_ACT,
    output logic [4:0] INPUT_POS,
    input  logic [7:0] INPUT_DATA,
    input  logic       INPUT_WE,
    output logic       OREG_WE,
    output logic [4:0] OREG_ADDR,
    output logic [7:0] OREG_DATA,
    output logic       CHUNK_RDY,
    output logic       MORE,
    output logic       ERR,
    output logic       BUSY
);

    localparam logic [4:0] LAST_POS = 5'(OREG_SIZE - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    seq_state_e state_q;
    logic [4:0] pos_q;
    logic [7:0] total_q;
    logic [7:0] skipCnt_q;
    logic [7:0] timer_q;
    logic       inputAct_q;
    logic       oregWe_q;
    logic [4:0] oregAddr_q;
    logic [7:0] oregData_q;
    logic       chunkRdy_q;
    logic       more_q;
    logic       err_q;

    logic accept;
    logic parserLoad;
    logic parserValid;
    logic parserComplete;

    assign accept      = SMPC_CE & INPUT_WE & inputAct_q;
    assign parserLoad  = SMPC_CE & START & (state_q == ST_IDLE);
    assign parserValid = accept & ~BREAK & (state_q == ST_CAPTURE);

    periph_stream_parser #(
        .NUM_PORTS (NUM_PORTS)
    ) u_parser (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load_i     (parserLoad),
        .byte_i     (INPUT_DATA),
        .valid_i    (parserValid),
        .complete_o (parserComplete)
    );

    // Strobes default low each CLK; all other state moves only on SMPC_CE ticks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            pos_q      <= 5'd0;
            total_q    <= 8'd0;
            skipCnt_q  <= 8'd0;
            timer_q    <= 8'd0;
            inputAct_q <= 1'b0;
            oregWe_q   <= 1'b0;
            oregAddr_q <= 5'd0;
            oregData_q <= 8'd0;
            chunkRdy_q <= 1'b0;
            more_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            oregWe_q   <= 1'b0;
            chunkRdy_q <= 1'b0;
            if (SMPC_CE) begin
                if (BREAK && state_q != ST_IDLE) begin
                    state_q    <= ST_IDLE;
                    inputAct_q <= 1'b0;
                    more_q     <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (START) begin
                                total_q    <= 8'd0;
                                skipCnt_q  <= 8'd0;
                                pos_q      <= 5'd0;
                                timer_q    <= 8'd0;
                                err_q      <= 1'b0;
                                more_q     <= 1'b0;
                                inputAct_q <= 1'b1;
                                state_q    <= ST_CAPTURE;
                            end
                        end
                        ST_CAPTURE: begin
                            if (accept) begin
                                oregWe_q   <= 1'b1;
                                oregAddr_q <= pos_q;
                                oregData_q <= INPUT_DATA;
                                pos_q      <= pos_q + 5'd1;
                                total_q    <= total_q + 8'd1;
                                timer_q    <= 8'd0;
                                if (parserComplete) begin
                                    inputAct_q <= 1'b0;
                                    chunkRdy_q <= 1'b1;
                                    more_q     <= 1'b0;
                                    state_q    <= ST_IDLE;
                                end else if (pos_q == LAST_POS) begin
                                    inputAct_q <= 1'b0;
                                    chunkRdy_q <= 1'b1;
                                    more_q     <= 1'b1;
                                    skipCnt_q  <= total_q + 8'd1;
                                    state_q    <= ST_WAIT_CONT;
                                end
                            end else if (timer_q == TMO_LAST) begin
                                inputAct_q <= 1'b0;
                                chunkRdy_q <= 1'b1;
                                more_q     <= 1'b0;
                                err_q      <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                timer_q <= timer_q + 8'd1;
                            end
                        end
                        ST_WAIT_CONT: begin
                            if (CONT) state_q <= ST_REARM;
                        end
                        // The low INPUT_ACT tick makes the serializer replay its stream from byte 0.
                        ST_REARM: begin
                            inputAct_q <= 1'b1;
                            pos_q      <= 5'd0;
                            timer_q    <= 8'd0;
                            state_q    <= (skipCnt_q == 8'd0) ? ST_CAPTURE : ST_SKIP;
                        end
                        ST_SKIP: begin
                            if (accept) begin
                                timer_q   <= 8'd0;
                                skipCnt_q <= skipCnt_q - 8'd1;
                                if (skipCnt_q == 8'd1) state_q <= ST_CAPTURE;
                            end else if (timer_q == TMO_LAST) begin
                                inputAct_q <= 1'b0;
                                chunkRdy_q <= 1'b1;
                                more_q     <= 1'b0;
                                err_q      <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                timer_q <= timer_q + 8'd1;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign INPUT_ACT = inputAct_q;
    assign INPUT_POS = pos_q;
    assign OREG_WE   = oregWe_q;
    assign OREG_ADDR = oregAddr_q;
    assign OREG_DATA = oregData_q;
    assign CHUNK_RDY = chunkRdy_q;
    assign MORE      = more_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_smpc_periph_seq.sv
// Directed bench for smpc_periph_seq with a replaying pad-serializer model and OREG shadow.
// Built with an 8-byte OREG window and a 16-tick timeout so chunking and timeout are reachable.
module tb_smpc_periph_seq;
    import smpc_pkg::*;

    localparam int OREG_SIZE = 8;
    localparam int NUM_PORTS = 2;
    localparam int TIMEOUT   = 16;

    logic       CLK, RST_N, SMPC_CE, START, CONT, BREAK;
    logic       INPUT_ACT, INPUT_WE, OREG_WE, CHUNK_RDY, MORE, ERR, BUSY;
    logic [4:0] INPUT_POS, OREG_ADDR;
    logic [7:0] INPUT_DATA, OREG_DATA;
    logic [23:0] allOut;

    int compared   = 0;
    int mismatched = 0;
    int weCount    = 0;
    int chunkCount = 0;
    int streamLen  = 0;
    logic serEnable = 1'b0;
    logic [7:0] oregMem   [0:31];
    logic [7:0] streamMem [0:31];

    logic [15:0] joy1 = 16'hFFF7;
    logic [15:0] joy2 = 16'hFFFF;
    logic [15:0] joy3 = 16'hFEFF;
    logic [7:0] expTwoPads [0:7] = '{8'hF1, 8'h02, 8'hFF, 8'hF7, 8'hF1, 8'h02, 8'hFF, 8'hFF};
    logic [7:0] expOnePad  [0:4] = '{8'hF0, 8'hF1, 8'h02, 8'hFE, 8'hFF};
    logic [7:0] expC1      [0:7] = '{8'hF1, 8'h19, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [7:0] expC2      [0:7] = '{8'hA6, 8'hA7, 8'hA8, 8'hF1, 8'h19, 8'hB0, 8'hB1, 8'hB2};
    logic [7:0] expC3      [0:5] = '{8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};

    assign allOut = {INPUT_ACT, INPUT_POS, OREG_WE, OREG_ADDR, OREG_DATA, CHUNK_RDY, MORE, ERR, BUSY};

    smpc_periph_seq #(
        .OREG_SIZE (OREG_SIZE),
        .NUM_PORTS (NUM_PORTS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SMPC_CE    (SMPC_CE),
        .START      (START),
        .CONT       (CONT),
        .BREAK      (BREAK),
        .INPUT_ACT  (INPUT_ACT),
        .INPUT_POS  (INPUT_POS),
        .INPUT_DATA (INPUT_DATA),
        .INPUT_WE   (INPUT_WE),
        .OREG_WE    (OREG_WE),
        .OREG_ADDR  (OREG_ADDR),
        .OREG_DATA  (OREG_DATA),
        .CHUNK_RDY  (CHUNK_RDY),
        .MORE       (MORE),
        .ERR        (ERR),
        .BUSY       (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Serializer model: replays the stream from byte 0 whenever INPUT_ACT is low.
    initial begin
        int   idx;
        logic pend;
        idx        = 0;
        pend       = 1'b0;
        INPUT_WE   = 1'b0;
        INPUT_DATA = 8'h00;
        forever begin
            @(negedge CLK);
            #1;
            if (pend) idx++;
            if (!INPUT_ACT) idx = 0;
            if (INPUT_ACT && serEnable && idx < streamLen) begin
                INPUT_DATA = streamMem[idx];
                INPUT_WE   = 1'b1;
            end else begin
                INPUT_DATA = 8'h00;
                INPUT_WE   = 1'b0;
            end
            pend = INPUT_WE && INPUT_ACT && SMPC_CE;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (OREG_WE === 1'b1) begin
            oregMem[OREG_ADDR] = OREG_DATA;
            weCount++;
        end
        if (CHUNK_RDY === 1'b1) chunkCount++;
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic b);
        START = s;
        CONT  = c;
        BREAK = b;
        tick();
        START = 1'b0;
        CONT  = 1'b0;
        BREAK = 1'b0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 32; i++) oregMem[i] = 8'h5A;
        weCount = 0;
    endtask

    task automatic push(input logic [7:0] b);
        streamMem[streamLen] = b;
        streamLen++;
    endtask

    task automatic waitChunk(input string tag, input int budget);
        int n0;
        int spent;
        n0    = chunkCount;
        spent = 0;
        while (chunkCount == n0 && spent < budget) begin
            tick();
            spent++;
        end
        checkOutput(tag, 32'(chunkCount - n0), 32'd1);
    endtask

    task automatic loadTwoPads();
        streamLen = 0;
        push(PERIPH_DIRECT); push(PAD_ID_DIGITAL); push(joy1[15:8]); push(joy1[7:0]);
        push(PERIPH_DIRECT); push(PAD_ID_DIGITAL); push(joy2[15:8]); push(joy2[7:0]);
    endtask

    initial begin
        int lowTicks;
        int ticks;
        int n;
        int guard;

        RST_N   = 1'b0;
        SMPC_CE = 1'b1;
        START   = 1'b0;
        CONT    = 1'b0;
        BREAK   = 1'b0;
        clearMem();
        repeat (3) @(negedge CLK);
        checkOutput("reset_outputs", 32'(allOut), 32'd0);
        RST_N = 1'b1;
        tick();

        SMPC_CE = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_without_ce", 32'(BUSY), 32'd0);
        SMPC_CE = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("cont_in_idle", 32'(BUSY), 32'd0);

        // Two digital pads: 8 bytes fill the window exactly and also complete the stream.
        loadTwoPads();
        serEnable = 1'b1;
        clearMem();
        n = chunkCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_busy", 32'(BUSY), 32'd1);
        waitChunk("t1_chunk", 40);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("t1_oreg%0d", i), 32'(oregMem[i]), 32'(expTwoPads[i]));
        checkOutput("t1_we_count", 32'(weCount), 32'd8);
        checkOutput("t1_more", 32'(MORE), 32'd0);
        checkOutput("t1_err", 32'(ERR), 32'd0);
        checkOutput("t1_busy_done", 32'(BUSY), 32'd0);
        repeat (3) tick();
        checkOutput("t1_one_chunk", 32'(chunkCount - n), 32'd1);
        checkOutput("t1_act_low", 32'(INPUT_ACT), 32'd0);

        // Port 1 unconnected, port 2 digital.
        streamLen = 0;
        push(PERIPH_UNCONNECTED); push(PERIPH_DIRECT); push(PAD_ID_DIGITAL); push(joy3[15:8]); push(joy3[7:0]);
        clearMem();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitChunk("t2_chunk", 40);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("t2_oreg%0d", i), 32'(oregMem[i]), 32'(expOnePad[i]));
        checkOutput("t2_we_count", 32'(weCount), 32'd5);
        checkOutput("t2_more", 32'(MORE), 32'd0);
        checkOutput("t2_busy", 32'(BUSY), 32'd0);

        // Two dual-mission pads: 22 bytes split 8 / 8 / 6.
        streamLen = 0;
        push(PERIPH_DIRECT); push(PAD_ID_DUAL_MISSION);
        for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
        push(PERIPH_DIRECT); push(PAD_ID_DUAL_MISSION);
        for (int i = 0; i < 9; i++) push(8'hB0 + 8'(i));
        clearMem();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitChunk("t3_chunk1", 40);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("t3_c1_oreg%0d", i), 32'(oregMem[i]), 32'(expC1[i]));
        checkOutput("t3_c1_we_count", 32'(weCount), 32'd8);
        checkOutput("t3_c1_more", 32'(MORE), 32'd1);
        checkOutput("t3_c1_busy", 32'(BUSY), 32'd1);
        checkOutput("t3_c1_act", 32'(INPUT_ACT), 32'd0);
        checkOutput("t3_c1_pos", 32'(INPUT_POS), 32'd8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_start_while_busy_pos", 32'(INPUT_POS), 32'd8);
        checkOutput("t3_start_while_busy_act", 32'(INPUT_ACT), 32'd0);

        clearMem();
        CONT = 1'b1;
        tick();
        CONT = 1'b0;
        lowTicks = 0;
        while (!INPUT_ACT && lowTicks < 10) begin
            lowTicks++;
            tick();
        end
        checkOutput("t3_rearm_low_ticks", 32'(lowTicks), 32'd1);
        checkOutput("t3_rearm_pos", 32'(INPUT_POS), 32'd0);
        waitChunk("t3_chunk2", 60);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("t3_c2_oreg%0d", i), 32'(oregMem[i]), 32'(expC2[i]));
        checkOutput("t3_c2_we_count", 32'(weCount), 32'd8);
        checkOutput("t3_c2_more", 32'(MORE), 32'd1);

        clearMem();
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitChunk("t3_chunk3", 80);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("t3_c3_oreg%0d", i), 32'(oregMem[i]), 32'(expC3[i]));
        checkOutput("t3_c3_oreg6_untouched", 32'(oregMem[6]), 32'h5A);
        checkOutput("t3_c3_we_count", 32'(weCount), 32'd6);
        checkOutput("t3_c3_more", 32'(MORE), 32'd0);
        checkOutput("t3_c3_busy", 32'(BUSY), 32'd0);

        // BREAK while waiting for CONT, then a fresh START restarts from byte 0.
        clearMem();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitChunk("t4_chunk1", 40);
        checkOutput("t4_more_before", 32'(MORE), 32'd1);
        n = chunkCount;
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        checkOutput("t4_busy", 32'(BUSY), 32'd0);
        checkOutput("t4_more", 32'(MORE), 32'd0);
        checkOutput("t4_act", 32'(INPUT_ACT), 32'd0);
        checkOutput("t4_no_chunk", 32'(chunkCount - n), 32'd0);
        clearMem();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitChunk("t4_restart_chunk", 40);
        checkOutput("t4_restart_oreg0", 32'(oregMem[0]), 32'hF1);
        checkOutput("t4_restart_oreg1", 32'(oregMem[1]), 32'h19);

        // BREAK on the same edge a byte is accepted: that byte must not be written.
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        clearMem();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        checkOutput("t4_break_byte_dropped", 32'(weCount), 32'd3);
        checkOutput("t4_break_busy", 32'(BUSY), 32'd0);

        // Timeout with the serializer silent.
        serEnable = 1'b0;
        clearMem();
        n = chunkCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks = 0;
        while (chunkCount == n && ticks < 40) begin
            tick();
            ticks++;
        end
        checkOutput("t5_timeout_ticks", 32'(ticks), 32'd16);
        checkOutput("t5_err", 32'(ERR), 32'd1);
        checkOutput("t5_more", 32'(MORE), 32'd0);
        checkOutput("t5_no_write", 32'(weCount), 32'd0);
        checkOutput("t5_busy", 32'(BUSY), 32'd0);
        repeat (3) tick();
        checkOutput("t5_err_held", 32'(ERR), 32'd1);
        serEnable = 1'b1;
        loadTwoPads();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5_err_cleared", 32'(ERR), 32'd0);
        waitChunk("t5_recover_chunk", 40);

        // Reset mid-capture after three bytes.
        clearMem();
        n = chunkCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (weCount < 3 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("t6_three_bytes", 32'(weCount), 32'd3);
        RST_N = 1'b0;
        #1;
        checkOutput("t6_async_reset_outputs", 32'(allOut), 32'd0);
        repeat (2) tick();
        checkOutput("t6_no_chunk", 32'(chunkCount - n), 32'd0);
        RST_N = 1'b1;
        tick();
        clearMem();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitChunk("t6_restart_chunk", 40);
        checkOutput("t6_restart_oreg0", 32'(oregMem[0]), 32'hF1);
        checkOutput("t6_restart_oreg7", 32'(oregMem[7]), 32'hFF);
        checkOutput("t6_restart_we_count", 32'(weCount), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/smpc_periph_seq.md
Name: smpc_periph_seq

Overview:
- Sequences the SMPC INTBACK peripheral-data phase: drives the pad serializer's INPUT_ACT and INPUT_POS, and captures its INPUT_DATA/INPUT_WE byte stream into the OREG window.
- Parses the per-port status/ID framing to detect end of data.
- Splits data longer than the OREG window into chunks using the SMPC continue/break protocol.
- Sits between the SMPC command FSM (START/CONT/BREAK) and the pad serializer.

Parameters:
- OREG_SIZE, 32, bytes per chunk (2..32).
- NUM_PORTS, 2, number of port records expected in the stream.
- TIMEOUT, 255, SMPC_CE ticks without a byte before the chunk is aborted.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- SMPC_CE  in  1  SMPC clock enable; all state advances only when high.
- START  in  1  pulse: begin peripheral collection.
- CONT  in  1  pulse: fetch the next chunk.
- BREAK  in  1  pulse: abort collection.
- INPUT_ACT  out  1  stream enable to the serializer.
- INPUT_POS  out  5  current OREG write index.
- INPUT_DATA  in  8  stream byte.
- INPUT_WE  in  1  stream byte valid.
- OREG_WE  out  1  OREG write strobe.
- OREG_ADDR  out  5  OREG write address.
- OREG_DATA  out  8  OREG write data.
- CHUNK_RDY  out  1  one-CLK pulse: chunk complete.
- MORE  out  1  level: further chunks pending.
- ERR  out  1  level: last chunk ended by timeout.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation returns to IDLE immediately with no CHUNK_RDY.
- Byte acceptance: a byte is accepted on a CLK where SMPC_CE=1, INPUT_WE=1 and INPUT_ACT=1. Each serializer byte is accepted exactly once.
- States: IDLE, CAPTURE, WAIT_CONT, REARM, SKIP.
  - IDLE: START (qualified by SMPC_CE) clears TOTAL, SKIP_CNT, POS and ERR; loads the parser; sets INPUT_ACT=1; goes to CAPTURE.
  - CAPTURE: each accepted byte is parsed. One CLK later, OREG_WE=1, OREG_ADDR=POS, OREG_DATA=byte (1-CLK latency). POS and TOTAL then increment.
  - Chunk end in CAPTURE:
    - Parser complete: INPUT_ACT=0, CHUNK_RDY pulse, MORE=0, go to IDLE.
    - Otherwise, POS reaches OREG_SIZE: INPUT_ACT=0, CHUNK_RDY pulse, MORE=1, SKIP_CNT=TOTAL, go to WAIT_CONT.
    - If both conditions hit on the same byte, the complete case wins (MORE=0).
  - WAIT_CONT: CONT moves to REARM.
  - REARM: INPUT_ACT held 0 for exactly one SMPC_CE tick so the serializer restarts its stream. Then INPUT_ACT=1, POS=0, go to SKIP.
  - SKIP: accepted bytes are discarded, with no OREG write and no parsing, until SKIP_CNT bytes have been counted; then go to CAPTURE. If SKIP_CNT=0, go to CAPTURE directly.
- Parser: tracks port count (0..NUM_PORTS), phase (STATUS/ID/DATA) and DATA_LEFT (4 bits).
  - STATUS byte with low nibble 0: port unconnected; port count +1.
  - Any other STATUS byte: next byte is ID.
  - ID byte: DATA_LEFT = ID[3:0]. If 0, port done; otherwise go to DATA.
  - DATA byte: DATA_LEFT decrements; at 0, port count +1.
  - Complete when port count reaches NUM_PORTS.
- Timeout: in CAPTURE and SKIP, count SMPC_CE ticks since the last accepted byte. At TIMEOUT: INPUT_ACT=0, ERR=1, MORE=0, CHUNK_RDY pulse, go to IDLE. ERR stays set until the next START.
- Control pulses:
  - BREAK in any non-IDLE state: IDLE, INPUT_ACT=0, MORE=0, no CHUNK_RDY. BREAK has priority over simultaneous CONT or byte acceptance; the byte is not written.
  - START while BUSY: ignored.
  - CONT outside WAIT_CONT: ignored.
- Widths: TOTAL and SKIP_CNT 8 bits (maximum stream is 2×17 bytes); POS 5 bits.
- INPUT_POS equals POS at all times.

Decomposition:
- smpc_pkg:
  - State enum.
  - Status constants PERIPH_UNCONNECTED=8'hF0 and PERIPH_DIRECT=8'hF1.
  - Pad ID constants 8'h02, 8'h13, 8'h15, 8'h16 and 8'h19.
  - Parser phase enum.
- One sub-module, periph_stream_parser: registered port count, phase and DATA_LEFT; inputs are load/byte/valid; output is complete.

Test Plan:
- Two digital pads, JOY1=16'hFFF7, JOY2=16'hFFFF, START.
  - Required: OREG[0..7] = F1 02 FF F7 F1 02 FF FF; 8 OREG_WE; one CHUNK_RDY; MORE=0; ERR=0.
- Port1 off, port2 digital 16'hFEFF.
  - Required: OREG[0..4] = F0 F1 02 FE FF; then IDLE with MORE=0.
- OREG_SIZE=8, both ports dual-mission (22 bytes).
  - Chunk 1: bytes 0..7, MORE=1.
  - CONT: INPUT_ACT low for exactly 1 CE tick; 8 bytes skipped; bytes 8..15 written to addresses 0..7, MORE=1.
  - Second CONT: bytes 16..21 written to addresses 0..5, MORE=0.
- BREAK while in WAIT_CONT.
  - Required: BUSY=0, MORE=0, INPUT_ACT=0, no CHUNK_RDY.
  - A following START writes stream byte 0 to address 0.
- TIMEOUT=16, INPUT_WE held 0 after START.
  - Required: CHUNK_RDY at the 16th CE tick; ERR=1; MORE=0; no OREG_WE.
- Assert RST_N low after 3 bytes captured.
  - Required: all outputs 0 asynchronously; the next START restarts from byte 0.
